and_response_checker: RTL and testbench
=======================================

Name: and_response_checker

Overview:
- Receive-side self-checking monitor for the lab N-input AND gate experiments.
- Takes the stimulus vectors driven into the gate under test and the gate's response.
- Computes the expected AND of each vector, delays it to match the response latency, and compares the two.
- Counts passes and errors, captures the first failing vector, and reports done after a full truth-table sweep of 2^N_IN checked vectors.

Parameters:
- N_IN, 4, input width of the AND under test; 1..8
- LAT, 1, cycles from vector accepted to response valid; 0..4, where 0 = same-cycle compare
- CNT_W, 8, width of the check/error counters; must be ≥ N_IN+1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears the run state and begins a sweep
- vec_valid  in  1  vector present on vec this cycle
- vec  in  N_IN  stimulus vector driven to the DUT
- resp  in  1  DUT output, aligned LAT cycles after its vector
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done=1; 1 iff err_count==0
- checked_count  out  CNT_W  number of compares performed
- err_count  out  CNT_W  number of mismatches
- first_fail_valid  out  1  a mismatch has been captured this sweep
- first_fail_vec  out  N_IN  vector of the first mismatch

Behaviour:
- Reset: state=IDLE; all outputs 0; delay pipeline flushed; issued counter 0.
- IDLE:
  - vec_valid and resp are ignored.
  - start → clear counters, first_fail and pipeline; go to RUN next cycle.
- RUN: busy=1.
  - A vector is accepted when vec_valid=1 and issued < 2^N_IN; issued increments.
  - On acceptance, {1, &vec, vec} enters an LAT-deep shift pipeline.
  - When the pipeline output valid is set, compare resp with the expected value:
    - checked_count increments.
    - On mismatch, err_count increments.
    - On the first mismatch, set first_fail_valid and latch first_fail_vec.
  - LAT=0: compare combinationally in the acceptance cycle, with no pipeline.
  - Vectors with vec_valid after issued reaches 2^N_IN are ignored.
  - Exit to DONE the cycle after the compare that makes checked_count==2^N_IN.
  - The pipeline drains LAT cycles after the final vector is issued.
- DONE:
  - done=1 and pass=(err_count==0); counts and first_fail hold.
  - start → same clear as IDLE; go to RUN.
- Back-to-back: a vector may be accepted every cycle; acceptance and compare in the same cycle are both performed.
- start while in RUN: ignored.
- Duplicate vectors are legal; each one is checked, and there is no coverage tracking.
- Counters saturate at 2^CNT_W-1, which is unreachable when CNT_W ≥ N_IN+1.
- vec_valid gaps: the pipeline still shifts every cycle, so latency is strictly LAT cycles from acceptance.
- rst at any cycle, including mid-sweep: immediate return to the reset state, and in-flight pipeline entries are discarded.
- X on resp with pipeline valid=1 counts as a mismatch.

Decomposition:
- Shared package lab_pkg holds:
  - State encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function and_reduce_exp.
  - Constant MAX_LAT=4.
- One sub-module, resp_delay_line: parameterised LAT-deep shift register of {valid, exp, vec}, with synchronous clear driven by rst or start.
- FSM and counters live in the top module.

Test Plan:
- Correct DUT, LAT=1, vectors 0..15 on consecutive cycles with a 1-cycle delayed correct AND → done asserted 17 cycles after the first vector; checked_count=16; err_count=0; pass=1; first_fail_valid=0.
- DUT stuck-at-1 for vec=4'b1001, with vector 4'b1001 applied twice → err_count=2; first_fail_vec=4'b1001; pass=0.
- vec_valid toggling 1/0 with 16 vectors spread over 32 cycles → checked_count=16; each compare lands exactly 1 cycle after its vector.
- LAT=0 build, correct response → 16 checks in 16 cycles; done on cycle 17; pass=1.
- rst pulsed after 7 vectors, then start plus a full sweep → counts restart at 0; final checked_count=16; no stale first_fail.
- 20 vectors sent, plus start asserted mid-RUN → only 16 checked; start ignored; done=1; a start pulse in DONE clears counters and re-enters RUN.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the AND-gate lab checker: FSM encoding, limits and
// the reference model for the expected gate output.
package lab_pkg;

    localparam int MAX_LAT  = 4;
    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Expected output of an n-input AND: reduction over the low n bits only.
    function automatic logic and_reduce_exp(input logic [MAX_N_IN-1:0] v, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_N_IN; i++) begin
            if (i < n) r = r & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/resp_delay_line.sv
// LAT-deep shift register carrying {valid, expected, vector} so the expected
// value arrives in step with the response of the gate under test.
module resp_delay_line
    import lab_pkg::*;
#(
    parameter int LAT = 1,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    input  logic         in_exp,
    input  logic [W-1:0] in_vec,
    output logic         out_valid,
    output logic         out_exp,
    output logic [W-1:0] out_vec
);

    if (LAT == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = clk ^ clear;
        assign out_valid = in_valid;
        assign out_exp   = in_exp;
        assign out_vec   = in_vec;
    end else begin : g_pipe
        logic [LAT-1:0] valid_q;
        logic [LAT-1:0] exp_q;
        logic [W-1:0]   vec_q [LAT];

        always_ff @(posedge clk) begin
            if (clear) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
            end
        end

        // NOTE: only the valid bits need clearing; data stages are always
        // qualified by valid, so they carry no reset.
        always_ff @(posedge clk) begin
            exp_q[0] <= in_exp;
            vec_q[0] <= in_vec;
            for (int i = 1; i < LAT; i++) begin
                exp_q[i] <= exp_q[i-1];
                vec_q[i] <= vec_q[i-1];
            end
        end

        assign out_valid = valid_q[LAT-1];
        assign out_exp   = exp_q[LAT-1];
        assign out_vec   = vec_q[LAT-1];
    end

endmodule

// File: rtl/and_response_checker.sv
// Self-checking monitor for an N-input AND under test: delays the expected
// AND to the response latency, compares, counts and reports a sweep result.
module and_response_checker
    import lab_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [N_IN-1:0]  vec,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] checked_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam logic [N_IN:0]    SWEEP_ISSUE = (N_IN+1)'(1) << N_IN;
    localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(SWEEP_ISSUE) - CNT_W'(1);

    state_t          state;
    logic [N_IN:0]   issued;
    logic            start_go;
    logic            line_clear;
    logic            accept;
    logic            exp_bit;
    logic            d_valid;
    logic            d_exp;
    logic [N_IN-1:0] d_vec;
    logic            cmp;
    logic            mismatch;

    assign start_go   = start && (state != RUN);
    assign line_clear = rst || start_go;
    assign accept     = (state == RUN) && vec_valid && (issued < SWEEP_ISSUE);
    assign exp_bit    = and_reduce_exp(MAX_N_IN'(vec), N_IN);

    resp_delay_line #(
        .LAT (LAT),
        .W   (N_IN)
    ) u_delay (
        .clk       (clk),
        .clear     (line_clear),
        .in_valid  (accept),
        .in_exp    (exp_bit),
        .in_vec    (vec),
        .out_valid (d_valid),
        .out_exp   (d_exp),
        .out_vec   (d_vec)
    );

    assign cmp = (state == RUN) && d_valid;
    // Case inequality so an unknown response is scored as a mismatch.
    assign mismatch = (resp !== d_exp);

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    // NOTE: every piece of state is updated here with non-blocking assignments,
    // so an acceptance and a compare in the same cycle both act on pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            issued           <= '0;
            checked_count    <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= RUN;
                        issued           <= '0;
                        checked_count    <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                RUN: begin
                    if (accept) issued <= issued + 1'b1;
                    if (cmp) begin
                        if (checked_count != '1) checked_count <= checked_count + 1'b1;
                        if (mismatch) begin
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= d_vec;
                            end
                        end
                        if (checked_count == SWEEP_LAST) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_response_checker.sv
// Bench for and_response_checker: LAT=0 and LAT=1 instances driven in parallel
// by a modelled gate, with a per-instance scoreboard and a scenario table.
module tb_and_response_checker;

    typedef struct {
        int due;
        bit mis;
    } sb_t;

    typedef struct {
        string name;
        int    n;
        bit    gap;
        bit    fault;
        bit    dup9;
        bit    mid_start;
        bit    timing;
        int    exp_chk;
        int    exp_err;
        bit    exp_pass;
        bit    exp_ffv;
        int    exp_ffvec;
    } scen_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec = '0;
    logic       fault = 1'b0;
    logic       gate_out;
    logic       resp0;
    logic       resp1 = 1'b0;

    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic       ffv [2];
    logic [7:0] chk [2];
    logic [7:0] err [2];
    logic [3:0] ffvec [2];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int model_issued = 0;
    int first_cyc = -1;
    int done_cyc [2] = '{-1, -1};
    int prev_chk [2] = '{0, 0};
    int prev_err [2] = '{0, 0};
    logic prev_done [2] = '{1'b0, 1'b0};

    sb_t   q0[$];
    sb_t   q1[$];
    scen_t tab [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: a correct AND, optionally stuck-at-1 for 4'b1001.
    assign gate_out = (&vec) | (fault & (vec == 4'b1001));
    assign resp0    = gate_out;
    always @(posedge clk) resp1 <= gate_out;

    and_response_checker #(.N_IN(4), .LAT(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .resp(resp0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .checked_count(chk[0]),
        .err_count(err[0]), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0])
    );

    and_response_checker #(.N_IN(4), .LAT(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .resp(resp1),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .checked_count(chk[1]),
        .err_count(err[1]), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1])
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input int d, output sb_t it, output bit ok);
        ok = 1'b0;
        it = '{-1, 1'b0};
        if (d == 0 && q0.size() > 0) begin it = q0.pop_front(); ok = 1'b1; end
        if (d == 1 && q1.size() > 0) begin it = q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic sb_peek(input int d, output sb_t it, output bit ok);
        ok = 1'b0;
        it = '{-1, 1'b0};
        if (d == 0 && q0.size() > 0) begin it = q0[0]; ok = 1'b1; end
        if (d == 1 && q1.size() > 0) begin it = q1[0]; ok = 1'b1; end
    endtask

    // Each counter step must match the oldest scoreboard entry, in the cycle it is due.
    task automatic monitor_dut(input int d);
        sb_t it;
        bit  ok;
        int  cur_chk;
        int  cur_err;
        cur_chk = int'(chk[d]);
        cur_err = int'(err[d]);
        if (cur_chk == prev_chk[d] + 1) begin
            sb_pop(d, it, ok);
            check($sformatf("dut%0d_cmp_due", d), ok ? it.due : -1, cyc);
            check($sformatf("dut%0d_cmp_err", d), cur_err - prev_err[d], ok ? int'(it.mis) : -1);
        end else begin
            sb_peek(d, it, ok);
            if (ok && it.due <= cyc) begin
                check($sformatf("dut%0d_cmp_missing", d), cur_chk - prev_chk[d], 1);
                sb_pop(d, it, ok);
            end
        end
        if (done[d] && !prev_done[d]) done_cyc[d] = cyc;
        prev_chk[d]  = cur_chk;
        prev_err[d]  = cur_err;
        prev_done[d] = done[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor_dut(d);
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        vec_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic drive_vec(input logic [3:0] v, input logic do_start);
        sb_t it;
        @(posedge clk); #1;
        vec       = v;
        vec_valid = 1'b1;
        start     = do_start;
        if (model_issued < 16) begin
            it.mis = fault && (v == 4'b1001);
            it.due = cyc + 1;
            q0.push_back(it);
            it.due = cyc + 2;
            q1.push_back(it);
            model_issued++;
        end
        if (first_cyc < 0) first_cyc = cyc;
    endtask

    task automatic check_idle_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_busy%0d", tag, d), busy[d], 0);
            check($sformatf("%s_done%0d", tag, d), done[d], 0);
            check($sformatf("%s_pass%0d", tag, d), pass[d], 0);
            check($sformatf("%s_chk%0d", tag, d), chk[d], 0);
            check($sformatf("%s_err%0d", tag, d), err[d], 0);
            check($sformatf("%s_ffv%0d", tag, d), ffv[d], 0);
            check($sformatf("%s_ffvec%0d", tag, d), ffvec[d], 0);
        end
    endtask

    task automatic start_sweep(input string tag);
        @(posedge clk); #1;
        vec_valid = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        model_issued = 0;
        first_cyc    = -1;
        done_cyc     = '{-1, -1};
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_start_busy%0d", tag, d), busy[d], 1);
            check($sformatf("%s_start_done%0d", tag, d), done[d], 0);
            check($sformatf("%s_start_chk%0d", tag, d), chk[d], 0);
            check($sformatf("%s_start_err%0d", tag, d), err[d], 0);
            check($sformatf("%s_start_ffv%0d", tag, d), ffv[d], 0);
        end
    endtask

    task automatic run_scenario(input scen_t s);
        int t;
        fault = s.fault;
        start_sweep(s.name);
        for (int i = 0; i < s.n; i++) begin
            logic [3:0] v;
            v = 4'(i % 16);
            if (s.dup9 && v == 4'd10) v = 4'd9;
            drive_vec(v, s.mid_start && (i == 5));
            if (s.gap) idle_cycle();
        end
        idle_cycle();
        t = 0;
        while (!(done[0] && done[1]) && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check({s.name, "_done_reached"}, done[0] && done[1], 1);
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_chk%0d", s.name, d), chk[d], s.exp_chk);
            check($sformatf("%s_err%0d", s.name, d), err[d], s.exp_err);
            check($sformatf("%s_pass%0d", s.name, d), pass[d], s.exp_pass);
            check($sformatf("%s_ffv%0d", s.name, d), ffv[d], s.exp_ffv);
            check($sformatf("%s_ffvec%0d", s.name, d), ffvec[d], s.exp_ffvec);
            check($sformatf("%s_busy%0d", s.name, d), busy[d], 0);
            if (s.timing) begin
                check($sformatf("%s_done_lat%0d", s.name, d), done_cyc[d] - first_cyc, 16 + d);
            end
        end
        check({s.name, "_sb0_left"}, q0.size(), 0);
        check({s.name, "_sb1_left"}, q1.size(), 0);
    endtask

    initial begin
        //         name      n  gap   fault dup9  mid   timing chk err pass  ffv   ffvec
        tab[0] = '{"sweep",  16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 0, 1'b1, 1'b0, 0};
        tab[1] = '{"stuck9", 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16, 2, 1'b0, 1'b1, 9};
        tab[2] = '{"gapped", 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 0, 1'b1, 1'b0, 0};
        tab[3] = '{"over20", 20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0, 1'b1, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_zero("reset");

        // Vectors presented while IDLE must not be counted.
        vec       = 4'hF;
        vec_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 vec_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("idle_vec");

        for (int k = 0; k < 4; k++) run_scenario(tab[k]);

        // Reset mid-sweep with a captured failure and an entry still in flight.
        fault = 1'b1;
        start_sweep("rst_mid");
        for (int i = 3; i <= 9; i++) drive_vec(4'(i), 1'b0);
        @(posedge clk); #1;
        vec_valid = 1'b0;
        check("pre_rst_ffv0", ffv[0], 1);
        check("pre_rst_ffvec0", ffvec[0], 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        check_idle_zero("post_rst");
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("post_rst_drain");
        fault = 1'b0;
        run_scenario(tab[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench timeout");
    end

endmodule
